// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake/status bundle between a producer/consumer and
// the sync_fifo_param buffer.
//   master modport : drives clear, write, read, data_in; observes data and status
//   slave modport  : the FIFO side, the mirror image of master
// count is $clog2(DEPTH+1) bits wide so it can represent 0..DEPTH.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clear;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, write, read, data_in,
        input  data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  clear, write, read, data_in,
        output data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with arbitrary depth, optional
// first-word fall-through, programmable almost flags, occupancy count,
// overflow/underflow pulses and synchronous flush.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : sync_fifo_param_if.slave (clear/write/read/data_in in,
//           data_out/status/count/error pulses out)
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_param: WIDTH must be >= 1");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx_reg;
    logic [IDX_W-1:0] rd_idx_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             full_w;
    logic             empty_w;
    logic             rd_ok;
    logic             wr_ok;
    logic             flush;

    // Indices wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Status is decoded from the registered count only.
    assign full_w  = (count_reg == CNT_W'(DEPTH));
    assign empty_w = (count_reg == '0);
    assign flush   = !rst_n || bus.clear;

    // A write into a full FIFO is only taken when a read frees a slot in the
    // same cycle; the freed slot is the one being written (wr_idx == rd_idx).
    assign rd_ok = bus.read && !empty_w;
    assign wr_ok = bus.write && (!full_w || rd_ok);

    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_idx_reg <= idx_inc(wr_idx_reg);
            end
            if (rd_ok) begin
                rd_idx_reg <= idx_inc(rd_idx_reg);
            end
            count_reg     <= count_next;
            overflow_reg  <= bus.write && !wr_ok;
            underflow_reg <= bus.read && !rd_ok;
        end
    end

    // Storage has no reset so it maps onto block RAM; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (!flush && wr_ok) begin
            mem[wr_idx_reg] <= bus.data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] data_out_reg;

            // On a full pass-through the read sees the old word (read before write).
            always_ff @(posedge clk) begin
                if (flush) begin
                    data_out_reg <= '0;
                end else if (rd_ok) begin
                    data_out_reg <= mem[rd_idx_reg];
                end
            end
            assign bus.data_out = data_out_reg;
        end else begin : g_fwft
            // Head word shown directly; forced to zero when nothing is stored.
            assign bus.data_out = empty_w ? '0 : mem[rd_idx_reg];
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks on DEPTH=6 instances (registered read and
// FWFT) plus randomized traffic on DEPTH 2/5/16 x FWFT 0/1, each compared every
// cycle against a queue-based reference model.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sweep_done = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- directed instance A: DEPTH 6, registered read ----------
    logic rst_a;
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(6)) if_a ();
    sync_fifo_param #(.WIDTH(8), .DEPTH(6), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(if_a)
    );

    // ---------------- directed instance B: DEPTH 6, FWFT ---------------------
    logic rst_b;
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(6)) if_b ();
    sync_fifo_param #(.WIDTH(8), .DEPTH(6), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(if_b)
    );

    // Called at a negedge: apply inputs for one rising edge, return at the
    // following negedge with inputs back to idle.
    task automatic step_a(input logic w, input logic r, input logic c, input logic rn, input logic [7:0] d);
        if_a.write = w; if_a.read = r; if_a.clear = c; rst_a = rn; if_a.data_in = d;
        @(negedge clk);
        if_a.write = 1'b0; if_a.read = 1'b0; if_a.clear = 1'b0; rst_a = 1'b1; if_a.data_in = '0;
    endtask

    task automatic step_b(input logic w, input logic r, input logic [7:0] d);
        if_b.write = w; if_b.read = r; if_b.data_in = d;
        @(negedge clk);
        if_b.write = 1'b0; if_b.read = 1'b0; if_b.data_in = '0;
    endtask

    // ---------------- randomized sweep ---------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_sweep
            localparam int D = (gi < 2) ? 2 : ((gi < 4) ? 5 : 16);
            localparam int F = gi % 2;
            logic rst_s;
            sync_fifo_param_if #(.WIDTH(8), .DEPTH(D)) if_s ();
            sync_fifo_param #(.WIDTH(8), .DEPTH(D), .FWFT(F), .AF_LEVEL(D - 1), .AE_LEVEL(1)) dut_s (
                .clk(clk), .rst_n(rst_s), .bus(if_s)
            );

            initial begin : stim
                logic [7:0] q[$];
                logic [7:0] dout_m;
                logic [7:0] din;
                logic       ovf_m, unf_m, w, r, c, rn, rd_acc, wr_acc;
                int         n, bias;
                rst_s = 1'b0;
                if_s.clear = 1'b0; if_s.write = 1'b0; if_s.read = 1'b0; if_s.data_in = '0;
                @(negedge clk);
                @(negedge clk);
                rst_s = 1'b1;
                dout_m = '0; ovf_m = 1'b0; unf_m = 1'b0;
                for (int cyc = 0; cyc < 600; cyc++) begin
                    n = q.size();
                    check_val($sformatf("D%0d_F%0d count", D, F), 32'(if_s.count), n);
                    check_val($sformatf("D%0d_F%0d empty", D, F), if_s.empty, n == 0);
                    check_val($sformatf("D%0d_F%0d full", D, F), if_s.full, n == D);
                    check_val($sformatf("D%0d_F%0d afull", D, F), if_s.almost_full, n >= D - 1);
                    check_val($sformatf("D%0d_F%0d aempty", D, F), if_s.almost_empty, n <= 1);
                    check_val($sformatf("D%0d_F%0d ovf", D, F), if_s.overflow, ovf_m);
                    check_val($sformatf("D%0d_F%0d unf", D, F), if_s.underflow, unf_m);
                    if (F == 1) begin
                        check_val($sformatf("D%0d_F%0d dout", D, F), if_s.data_out, (n > 0) ? q[0] : 8'h00);
                    end else begin
                        check_val($sformatf("D%0d_F%0d dout", D, F), if_s.data_out, dout_m);
                    end

                    // Alternate write-heavy and read-heavy phases to sweep occupancy.
                    bias = ((cyc / 50) % 2 == 1) ? 75 : 25;
                    w   = ($urandom_range(0, 99) < bias);
                    r   = ($urandom_range(0, 99) < 100 - bias);
                    c   = ($urandom_range(0, 199) == 0);
                    rn  = ($urandom_range(0, 199) != 0);
                    din = 8'($urandom);
                    if_s.write = w; if_s.read = r; if_s.clear = c; rst_s = rn; if_s.data_in = din;

                    if (!rn || c) begin
                        q.delete();
                        dout_m = '0; ovf_m = 1'b0; unf_m = 1'b0;
                    end else begin
                        rd_acc = r && (q.size() > 0);
                        wr_acc = w && ((q.size() < D) || rd_acc);
                        ovf_m  = w && !wr_acc;
                        unf_m  = r && !rd_acc;
                        if (rd_acc) begin
                            dout_m = q.pop_front();
                        end
                        if (wr_acc) begin
                            q.push_back(din);
                        end
                    end
                    @(negedge clk);
                end
                if_s.write = 1'b0; if_s.read = 1'b0; if_s.clear = 1'b0; rst_s = 1'b1;
                sweep_done++;
            end
        end
    endgenerate

    // ---------------- directed sequences -------------------------------------
    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        if_a.clear = 1'b0; if_a.write = 1'b0; if_a.read = 1'b0; if_a.data_in = '0;
        if_b.clear = 1'b0; if_b.write = 1'b0; if_b.read = 1'b0; if_b.data_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        // reset state
        check_val("rst count", 32'(if_a.count), 0);
        check_val("rst empty", if_a.empty, 1);
        check_val("rst full", if_a.full, 0);
        check_val("rst aempty", if_a.almost_empty, 1);
        check_val("rst afull", if_a.almost_full, 0);
        check_val("rst ovf", if_a.overflow, 0);
        check_val("rst unf", if_a.underflow, 0);
        check_val("rst dout", if_a.data_out, 0);

        // fill and overflow
        for (int i = 0; i < 6; i++) begin
            step_a(1, 0, 0, 1, 8'(8'h10 + i));
            check_val("fill count", 32'(if_a.count), i + 1);
            check_val("fill afull", if_a.almost_full, (i + 1) >= 4);
            check_val("fill full", if_a.full, (i + 1) == 6);
            check_val("fill ovf", if_a.overflow, 0);
        end
        step_a(1, 0, 0, 1, 8'hFF);
        check_val("ovf pulse", if_a.overflow, 1);
        check_val("ovf count", 32'(if_a.count), 6);
        step_a(0, 0, 0, 1, 8'h00);
        check_val("ovf one cycle", if_a.overflow, 0);
        for (int i = 0; i < 6; i++) begin
            step_a(0, 1, 0, 1, 8'h00);
            check_val("drain data", if_a.data_out, 8'h10 + i);
            check_val("drain unf", if_a.underflow, 0);
            check_val("drain count", 32'(if_a.count), 5 - i);
        end

        // wrap-around across index 5 -> 0
        for (int i = 0; i < 4; i++) step_a(1, 0, 0, 1, 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            step_a(0, 1, 0, 1, 8'h00);
            check_val("pre-wrap data", if_a.data_out, 8'h30 + i);
        end
        for (int i = 0; i < 6; i++) step_a(1, 0, 0, 1, 8'(8'h20 + i));
        for (int i = 0; i < 6; i++) begin
            step_a(0, 1, 0, 1, 8'h00);
            check_val("wrap data", if_a.data_out, 8'h20 + i);
        end
        check_val("wrap empty", if_a.empty, 1);
        check_val("wrap aempty", if_a.almost_empty, 1);

        // read+write while full
        for (int i = 0; i < 6; i++) step_a(1, 0, 0, 1, 8'(8'h50 + i));
        step_a(1, 1, 0, 1, 8'h99);
        check_val("pass data", if_a.data_out, 8'h50);
        check_val("pass count", 32'(if_a.count), 6);
        check_val("pass ovf", if_a.overflow, 0);
        for (int i = 0; i < 5; i++) begin
            step_a(0, 1, 0, 1, 8'h00);
            check_val("pass drain", if_a.data_out, 8'h51 + i);
        end
        step_a(0, 1, 0, 1, 8'h00);
        check_val("pass last", if_a.data_out, 8'h99);
        check_val("pass empty", if_a.empty, 1);

        // read+write while empty
        step_a(1, 1, 0, 1, 8'h42);
        check_val("empty rw count", 32'(if_a.count), 1);
        check_val("empty rw unf", if_a.underflow, 1);
        check_val("empty rw hold", if_a.data_out, 8'h99);
        step_a(0, 1, 0, 1, 8'h00);
        check_val("empty rw data", if_a.data_out, 8'h42);
        check_val("empty rw unf off", if_a.underflow, 0);
        check_val("empty rw count0", 32'(if_a.count), 0);

        // flush by clear (k=0), then by reset (k=1), each with write+read high
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) step_a(1, 0, 0, 1, 8'(8'h60 + i));
            step_a(0, 1, 0, 1, 8'h00);
            check_val("pre-flush data", if_a.data_out, 8'h60);
            check_val("pre-flush count", 32'(if_a.count), 3);
            step_a(1, 1, (k == 0), (k == 0), 8'h77);
            check_val("flush count", 32'(if_a.count), 0);
            check_val("flush empty", if_a.empty, 1);
            check_val("flush afull", if_a.almost_full, 0);
            check_val("flush aempty", if_a.almost_empty, 1);
            check_val("flush ovf", if_a.overflow, 0);
            check_val("flush unf", if_a.underflow, 0);
            check_val("flush dout", if_a.data_out, 0);
            step_a(1, 0, 0, 1, 8'(8'h71 + k));
            step_a(0, 1, 0, 1, 8'h00);
            check_val("post-flush data", if_a.data_out, 8'h71 + k);
            check_val("post-flush count", 32'(if_a.count), 0);
        end

        // FWFT instance
        check_val("fwft rst dout", if_b.data_out, 0);
        check_val("fwft rst empty", if_b.empty, 1);
        step_b(1, 0, 8'hA5);
        check_val("fwft first", if_b.data_out, 8'hA5);
        check_val("fwft not empty", if_b.empty, 0);
        step_b(1, 0, 8'hA6);
        check_val("fwft head held", if_b.data_out, 8'hA5);
        check_val("fwft count2", 32'(if_b.count), 2);
        step_b(0, 1, 8'h00);
        check_val("fwft second", if_b.data_out, 8'hA6);
        step_b(0, 1, 8'h00);
        check_val("fwft drained", if_b.data_out, 0);
        check_val("fwft empty", if_b.empty, 1);

        for (int i = 0; i < 20000 && sweep_done < 6; i++) @(negedge clk);
        check_val("sweep done", sweep_done, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
